// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundles the fetch-stage control inputs, the branch-target LUT
// handshake and the program-counter status outputs into one port.
// master = the fetch stage itself, slave = decode/LUT/host environment.
interface pc_fetch_if #(
    parameter int PC_W   = 16,
    parameter int LUT_AW = 8
) ();

    logic              start;
    logic [PC_W-1:0]   start_pc;
    logic              halt;
    logic              branch_en;
    logic              branch_rel;
    logic [LUT_AW-1:0] lut_idx;
    logic [LUT_AW-1:0] lut_addr;
    logic [PC_W-1:0]   lut_out;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic [15:0]       cycle_cnt;

    modport master (
        input  start,
        input  start_pc,
        input  halt,
        input  branch_en,
        input  branch_rel,
        input  lut_idx,
        input  lut_out,
        output lut_addr,
        output pc,
        output running,
        output done,
        output cycle_cnt
    );

    modport slave (
        output start,
        output start_pc,
        output halt,
        output branch_en,
        output branch_rel,
        output lut_idx,
        output lut_out,
        input  lut_addr,
        input  pc,
        input  running,
        input  done,
        input  cycle_cnt
    );

endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencer in front of the branch-target
// LUT. Starts at a selectable entry point, steps sequentially or jumps to an
// absolute / PC-relative LUT target, stops on halt and reports the number of
// executed (RUN) cycles, saturating at 0xFFFF.
module pc_fetch #(
    parameter int PC_W   = 16,
    parameter int LUT_AW = 8
) (
    input  logic      clk,
    input  logic      reset,
    pc_fetch_if.master bus
);

    localparam int CNT_W = 16;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = 16'h0001;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // One bit per visible status so running/done come straight off a flop.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [LUT_AW-1:0] lut_addr_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    // Next sequential / branch address for a non-halting RUN cycle.
    // Relative targets are two's complement offsets; the modulo-2^PC_W add
    // gives backward steps for free (0xFFFF == -1).
    function automatic logic [PC_W-1:0] next_pc(
        input logic [PC_W-1:0] cur_pc,
        input logic            br_en,
        input logic            br_rel,
        input logic [PC_W-1:0] target
    );
        logic [PC_W-1:0] res;
        if (br_en) begin
            if (br_rel) begin
                res = cur_pc + target;
            end else begin
                res = target;
            end
        end else begin
            res = cur_pc + PC_ONE;
        end
        return res;
    endfunction

    // The LUT is read in the decode cycle, so its index is a pure pass-through.
    assign lut_addr_s   = bus.lut_idx;
    assign bus.lut_addr = lut_addr_s;

    // Next-state and next-datapath decode; halt outranks branch, start is only
    // honoured outside RUN.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                    pc_s    = bus.start_pc;
                    cnt_s   = '0;
                end else begin
                    state_s = state_r;
                    pc_s    = pc_r;
                    cnt_s   = cnt_r;
                end
            end
            ST_RUN: begin
                // The halt cycle itself is an executed instruction and counts.
                cnt_s = sat_inc(cnt_r);
                if (bus.halt) begin
                    state_s = ST_DONE;
                    pc_s    = pc_r;
                end else begin
                    state_s = ST_RUN;
                    pc_s    = next_pc(pc_r, bus.branch_en, bus.branch_rel, bus.lut_out);
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Program counter and cycle counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= '0;
            cnt_r <= '0;
        end else begin
            pc_r  <= pc_s;
            cnt_r <= cnt_s;
        end
    end

    assign bus.pc        = pc_r;
    assign bus.cycle_cnt = cnt_r;
    assign bus.running   = state_r[0];
    assign bus.done      = state_r[1];

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed stimulus for pc_fetch. The stimulus process pushes
// hand-computed expectations into a scoreboard queue tagged with the clock
// edge after which they hold; an independent monitor pops and compares them
// on the falling edge.
module tb_pc_fetch;

    logic clk;
    logic reset;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    pc_fetch_if #(.PC_W(16), .LUT_AW(8)) bus ();

    pc_fetch #(.PC_W(16), .LUT_AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        int          tag;
        string       name;
        logic        is_lut;
        logic [7:0]  lut;
        logic [15:0] pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Branch-target LUT contents
    always_comb begin
        case (bus.lut_addr)
            8'd0:    bus.lut_out = 16'h0000;
            8'd3:    bus.lut_out = 16'h0040;
            8'd4:    bus.lut_out = 16'hFFFC;
            8'd5:    bus.lut_out = 16'h0005;
            8'd6:    bus.lut_out = 16'h0020;
            8'd7:    bus.lut_out = 16'hFFFF;
            8'd8:    bus.lut_out = 16'hFFFE;
            8'd9:    bus.lut_out = 16'h0008;
            8'd10:   bus.lut_out = 16'h0033;
            default: bus.lut_out = 16'h1234;
        endcase
    end

    task automatic apply(input logic rst, input logic st, input logic [15:0] spc,
                         input logic h, input logic br, input logic rel,
                         input logic [7:0] idx);
        reset          = rst;
        bus.start      = st;
        bus.start_pc   = spc;
        bus.halt       = h;
        bus.branch_en  = br;
        bus.branch_rel = rel;
        bus.lut_idx    = idx;
    endtask

    // Expected status after the coming rising edge
    task automatic exp_after(input string name, input logic [15:0] pc,
                             input logic run, input logic done, input logic [15:0] cnt);
        exp_t e;
        e.tag = edge_cnt + 1; e.name = name; e.is_lut = 1'b0; e.lut = 8'h00;
        e.pc = pc; e.run = run; e.done = done; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Expected LUT address in the current cycle
    task automatic exp_lut(input string name, input logic [7:0] addr);
        exp_t e;
        e.tag = edge_cnt; e.name = name; e.is_lut = 1'b1; e.lut = addr;
        e.pc = 16'h0000; e.run = 1'b0; e.done = 1'b0; e.cnt = 16'h0000;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every due expectation on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].tag <= edge_cnt) begin
                e = sb_q.pop_front();
                checks++;
                if (e.tag < edge_cnt) begin
                    failures++;
                    $display("FAIL %s: expectation for edge %0d not checked (now %0d)",
                             e.name, e.tag, edge_cnt);
                end else if (e.is_lut) begin
                    if (bus.lut_addr !== e.lut) begin
                        failures++;
                        $display("FAIL %s: lut_addr=%h required %h", e.name, bus.lut_addr, e.lut);
                    end
                end else if (bus.pc !== e.pc || bus.running !== e.run ||
                             bus.done !== e.done || bus.cycle_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: pc=%h run=%b done=%b cnt=%h required pc=%h run=%b done=%b cnt=%h",
                             e.name, bus.pc, bus.running, bus.done, bus.cycle_cnt,
                             e.pc, e.run, e.done, e.cnt);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        // Reset held with start high: nothing may leave reset values
        apply(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("reset_1", 16'h0000, 1'b0, 1'b0, 16'h0000); tick();
        exp_after("reset_2", 16'h0000, 1'b0, 1'b0, 16'h0000); tick();

        // Release reset with start held: RUN at 0x0010
        apply(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("start_seq", 16'h0010, 1'b1, 1'b0, 16'h0000); tick();

        // Sequential stepping 0x10 -> 0x14
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("seq_11", 16'h0011, 1'b1, 1'b0, 16'h0001); tick();
        exp_after("seq_12", 16'h0012, 1'b1, 1'b0, 16'h0002); tick();
        exp_after("seq_13", 16'h0013, 1'b1, 1'b0, 16'h0003); tick();
        exp_after("seq_14", 16'h0014, 1'b1, 1'b0, 16'h0004); tick();

        // Halt at 0x14: five instructions executed
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        exp_after("halt_seq", 16'h0014, 1'b0, 1'b1, 16'h0005); tick();

        // DONE ignores halt and branch
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd3);
        exp_after("done_hold", 16'h0014, 1'b0, 1'b1, 16'h0005); tick();

        // Start together with halt in DONE: start wins
        apply(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 8'd0);
        exp_after("restart_2", 16'h0002, 1'b1, 1'b0, 16'h0000); tick();

        // Absolute branch via LUT entry 3
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd3);
        exp_lut("lut_addr_3", 8'd3);
        exp_after("abs_br_40", 16'h0040, 1'b1, 1'b0, 16'h0001); tick();

        // Start while running is ignored
        apply(1'b0, 1'b1, 16'h0099, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("start_in_run", 16'h0041, 1'b1, 1'b0, 16'h0002); tick();

        // Reach 0x20, then relative -4
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd6);
        exp_after("abs_br_20", 16'h0020, 1'b1, 1'b0, 16'h0003); tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd4);
        exp_lut("lut_addr_4", 8'd4);
        exp_after("rel_back_1c", 16'h001C, 1'b1, 1'b0, 16'h0004); tick();

        // Sequential wrap 0xFFFF -> 0x0000
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd7);
        exp_after("abs_br_ffff", 16'hFFFF, 1'b1, 1'b0, 16'h0005); tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("seq_wrap", 16'h0000, 1'b1, 1'b0, 16'h0006); tick();

        // Relative wrap 0xFFFE + 5 -> 0x0003
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd8);
        exp_after("abs_br_fffe", 16'hFFFE, 1'b1, 1'b0, 16'h0007); tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd5);
        exp_lut("lut_addr_5", 8'd5);
        exp_after("rel_wrap_3", 16'h0003, 1'b1, 1'b0, 16'h0008); tick();

        // Halt and branch together at 0x0008: halt wins
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd9);
        exp_after("abs_br_8", 16'h0008, 1'b1, 1'b0, 16'h0009); tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd3);
        exp_after("halt_over_br", 16'h0008, 1'b0, 1'b1, 16'h000A); tick();

        // Restart from DONE at 0x0080
        apply(1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("restart_80", 16'h0080, 1'b1, 1'b0, 16'h0000); tick();

        // Mid-run reset at 0x0033 discards a pending branch
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd10);
        exp_after("abs_br_33", 16'h0033, 1'b1, 1'b0, 16'h0001); tick();
        apply(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd3);
        exp_after("mid_reset", 16'h0000, 1'b0, 1'b0, 16'h0000); tick();

        // IDLE ignores halt and branch
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd3);
        exp_after("idle_ignore", 16'h0000, 1'b0, 1'b0, 16'h0000); tick();

        // Branch-to-self loop for counter saturation
        apply(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 8'd0);
        exp_after("start_loop", 16'h0100, 1'b1, 1'b0, 16'h0000); tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 65533; i++) tick();
        exp_after("cnt_fffe", 16'h0100, 1'b1, 1'b0, 16'hFFFE); tick();
        exp_after("cnt_ffff", 16'h0100, 1'b1, 1'b0, 16'hFFFF); tick();
        for (int i = 0; i < 4465; i++) tick();
        exp_after("cnt_sat", 16'h0100, 1'b1, 1'b0, 16'hFFFF); tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        exp_after("halt_sat", 16'h0100, 1'b0, 1'b1, 16'hFFFF); tick();

        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        tick();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
